// File: rtl/uart_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_decoder
// Oversampling UART receiver with parity/framing checks and a FWFT byte FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
// Revision : 1.0
// ============================================================================
module uart_rx_decoder #(
   parameter int CLK_FREQ_MHZ = 27,
   parameter int BAUD_RATE    = 115200,
   parameter int OVERSAMPLE   = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        uart_rx,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_BITS-1:0]        out_data,
   output logic                        frame_err,
   output logic                        parity_err,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        break_det
);

   localparam int DIV_RAW = (CLK_FREQ_MHZ * 1000000) / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TCK_W   = $clog2(OVERSAMPLE);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = AW + 1;
   localparam int EW      = DATA_BITS + 2;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [TCK_W-1:0] HALF_LAST = TCK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TCK_W-1:0] BIT_LAST  = TCK_W'(OVERSAMPLE - 1);
   localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   logic [2:0]           state_q, state_d;
   logic                 rx_meta_q, rx_sync_q, rx_prev_q;
   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic [TCK_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 frm_err_q, frm_err_d;
   logic                 par_err_q, par_err_d;
   logic                 push_q;

   logic w_tick, w_fall, w_mid_start, w_mid_bit, w_stop_done, w_is_break;

   assign w_tick = (div_cnt_q == DIV_LAST);

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (w_fall) state_d = S_START;
         S_START:  if (w_mid_start) state_d = rx_sync_q ? S_IDLE : S_DATA;
         S_DATA:   if (w_mid_bit && (bit_cnt_q == DATA_LAST))
                      state_d = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (w_mid_bit) state_d = S_STOP;
         S_STOP:   if (w_stop_done) state_d = w_is_break ? S_BREAK : S_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
         S_BREAK:  if (rx_sync_q) state_d = S_IDLE;
`endif
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      w_fall      = 1'b0;
      w_mid_start = 1'b0;
      w_mid_bit   = 1'b0;
      w_stop_done = 1'b0;
      case (state_q)
         S_IDLE:           w_fall      = rx_prev_q & ~rx_sync_q;
         S_START:          w_mid_start = w_tick && (tick_cnt_q == HALF_LAST);
         S_DATA, S_PARITY: w_mid_bit   = w_tick && (tick_cnt_q == BIT_LAST);
         S_STOP: begin
            w_mid_bit   = w_tick && (tick_cnt_q == BIT_LAST);
            w_stop_done = w_mid_bit && (bit_cnt_q == STOP_LAST);
         end
         default: ;
      endcase
   end

   // ----------------------------------------------------------- datapath ---
   always_comb begin
      div_cnt_d  = w_tick ? '0 : div_cnt_q + 1'b1;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      frm_err_d  = frm_err_q;
      par_err_d  = par_err_q;
      // Re-phase the divider so ticks line up with the detected start edge.
      if (w_fall) div_cnt_d = '0;
      if (state_q == S_IDLE || w_mid_start || w_mid_bit) tick_cnt_d = '0;
      else if (w_tick)                                   tick_cnt_d = tick_cnt_q + 1'b1;
      if (w_mid_start) begin
         bit_cnt_d = '0;
         frm_err_d = 1'b0;
         par_err_d = 1'b0;
      end
      if (w_mid_bit) begin
         bit_cnt_d = (state_d != state_q) ? '0 : bit_cnt_q + 1'b1;
         case (state_q)
            S_DATA:   shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            S_PARITY: par_err_d = (PARITY == 1) ? ~^{shift_q, rx_sync_q}
                                                :  ^{shift_q, rx_sync_q};
            S_STOP:   if (!rx_sync_q) frm_err_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         div_cnt_q  <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         frm_err_q  <= 1'b0;
         par_err_q  <= 1'b0;
         push_q     <= 1'b0;
      end else begin
         rx_meta_q  <= uart_rx;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         div_cnt_q  <= div_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         frm_err_q  <= frm_err_d;
         par_err_q  <= par_err_d;
         push_q     <= w_stop_done & ~w_is_break;
      end
   end

   // -------------------------------------------------------------- break ---
`ifdef UART_RX_BREAK_DETECT_EN
   logic all_low_q, all_low_d;
   logic break_q;

   assign w_is_break = all_low_q & ~rx_sync_q;
   assign break_det  = break_q;

   always_comb begin
      all_low_d = all_low_q;
      if (w_mid_start)    all_low_d = ~rx_sync_q;
      else if (w_mid_bit) all_low_d = all_low_q & ~rx_sync_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         all_low_q <= 1'b0;
         break_q   <= 1'b0;
      end else begin
         all_low_q <= all_low_d;
         break_q   <= w_stop_done & w_is_break;
      end
   end
`else
   assign w_is_break = 1'b0;
   assign break_det  = 1'b0;
`endif

   // --------------------------------------------------------------- FIFO ---
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [EW-1:0] head_q, head_d, w_wdata;
   logic          valid_q, ovf_q, ovf_d;
   logic          w_pop, w_full, w_wr;

   assign w_pop   = valid_q & out_ready;
   assign w_full  = (count_q == FULL_CNT);
   assign w_wr    = push_q & (~w_full | w_pop);
   assign w_wdata = {par_err_q, frm_err_q, shift_q};

   // Head registers are loaded with whatever entry will sit at rd_ptr next cycle.
   always_comb begin
      rd_ptr_d = rd_ptr_q + AW'(w_pop);
      wr_ptr_d = wr_ptr_q + AW'(w_wr);
      count_d  = count_q + CW'(w_wr) - CW'(w_pop);
      ovf_d    = push_q & w_full & ~w_pop;
      if (count_d == '0)                       head_d = '0;
      else if (w_wr && (wr_ptr_q == rd_ptr_d)) head_d = w_wdata;
      else                                     head_d = mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (w_wr) mem_q[wr_ptr_q] <= w_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= (count_d != '0);
         ovf_q    <= ovf_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_data   = head_q[DATA_BITS-1:0];
   assign frame_err  = head_q[DATA_BITS];
   assign parity_err = head_q[DATA_BITS+1];
   assign overflow   = ovf_q;
   assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_decoder
// Self-checking bench: an 8N1/depth-8 instance and a 7E1/depth-4 instance.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_decoder;

   localparam int BIT = 224;   // clocks per bit: DIV 14 x OVERSAMPLE 16

`ifdef UART_RX_BREAK_DETECT_EN
   localparam int BRK_EN = 1;
`else
   localparam int BRK_EN = 0;
`endif

   typedef struct {
      logic [8:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   typedef struct {
      logic [7:0] din;
      logic       stop;
      logic [7:0] exp_d;
      logic       exp_fe;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       rx_a = 1'b1, ready_a = 1'b1;
   logic       valid_a, fe_a, pe_a, ovf_a, brk_a;
   logic [7:0] data_a;
   logic [3:0] cnt_a;

   logic       rx_b = 1'b1, ready_b = 1'b1;
   logic       valid_b, fe_b, pe_b, ovf_b, brk_b;
   logic [6:0] data_b;
   logic [2:0] cnt_b;

   int n_pass = 0;
   int n_total = 0;
   int brk_cnt_a = 0;
   int ovf_cnt_b = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;

   uart_rx_decoder u_dut_a (
      .clk(clk), .reset(reset), .uart_rx(rx_a),
      .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
      .frame_err(fe_a), .parity_err(pe_a), .overflow(ovf_a),
      .fifo_count(cnt_a), .break_det(brk_a)
   );

   uart_rx_decoder #(.DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(4)) u_dut_b (
      .clk(clk), .reset(reset), .uart_rx(rx_b),
      .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
      .frame_err(fe_b), .parity_err(pe_b), .overflow(ovf_b),
      .fifo_count(cnt_b), .break_det(brk_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tickn(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic v);
      if (sel == 0) rx_a = v;
      else          rx_b = v;
   endtask

   task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                             input int has_par, input logic pbit, input logic stop);
      drive(sel, 1'b0);
      tickn(BIT);
      for (int i = 0; i < nbits; i++) begin
         drive(sel, d[i]);
         tickn(BIT);
      end
      if (has_par != 0) begin
         drive(sel, pbit);
         tickn(BIT);
      end
      drive(sel, stop);
      tickn(BIT);
      drive(sel, 1'b1);
      tickn(BIT);
   endtask

   task automatic expect_a(input logic [8:0] d, input logic fe, input logic pe);
      exp_t e;
      e.d = d; e.fe = fe; e.pe = pe;
      q_a.push_back(e);
   endtask

   task automatic expect_b(input logic [8:0] d, input logic fe, input logic pe);
      exp_t e;
      e.d = d; e.fe = fe; e.pe = pe;
      q_b.push_back(e);
   endtask

   // Output monitors / scoreboards
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (brk_a) brk_cnt_a++;
         if (ovf_b) ovf_cnt_b++;
         if (valid_a && ready_a) begin
            if (q_a.size() == 0) begin
               n_total++;
               $display("FAIL popA_unexpected: got data 0x%0h, expected no output", data_a);
            end else begin
               e = q_a.pop_front();
               chk("popA_data", 32'(data_a), 32'(e.d));
               chk("popA_frame_err", 32'(fe_a), 32'(e.fe));
               chk("popA_parity_err", 32'(pe_a), 32'(e.pe));
            end
         end
         if (valid_b && ready_b) begin
            if (q_b.size() == 0) begin
               n_total++;
               $display("FAIL popB_unexpected: got data 0x%0h, expected no output", data_b);
            end else begin
               e = q_b.pop_front();
               chk("popB_data", 32'(data_b), 32'(e.d));
               chk("popB_frame_err", 32'(fe_b), 32'(e.fe));
               chk("popB_parity_err", 32'(pe_b), 32'(e.pe));
            end
         end
      end
   end

   initial begin
      vec_t va[6];
      logic [7:0] kb;
      va[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
      va[1] = '{8'hA3, 1'b1, 8'hA3, 1'b0};
      va[2] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
      va[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
      va[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
      va[5] = '{8'h96, 1'b0, 8'h96, 1'b1};

      // Reset state
      tickn(4);
      reset = 1'b0;
      tickn(2);
      chk("rst_valid_a", 32'(valid_a), 0);
      chk("rst_count_a", 32'(cnt_a), 0);
      chk("rst_data_a", 32'(data_a), 0);
      chk("rst_fe_a", 32'(fe_a), 0);
      chk("rst_pe_a", 32'(pe_a), 0);
      chk("rst_ovf_a", 32'(ovf_a), 0);
      chk("rst_brk_a", 32'(brk_a), 0);
      chk("rst_valid_b", 32'(valid_b), 0);
      chk("rst_count_b", 32'(cnt_b), 0);

      // Short low glitch must be rejected as a false start
      rx_a = 1'b0;
      tickn(3);
      rx_a = 1'b1;
      tickn(2 * BIT);
      chk("glitch_count", 32'(cnt_a), 0);
      chk("glitch_valid", 32'(valid_a), 0);

      // Table-driven 8N1 frames
      for (int i = 0; i < 6; i++) begin
         expect_a({1'b0, va[i].exp_d}, va[i].exp_fe, 1'b0);
         send_frame(0, {1'b0, va[i].din}, 8, 0, 1'b0, va[i].stop);
      end
      tickn(BIT);
      chk("tbl_count_a", 32'(cnt_a), 0);
      chk("tbl_pending_a", 32'(q_a.size()), 0);

      // Line held low for 20 bit times
      if (BRK_EN == 0) expect_a(9'h000, 1'b1, 1'b0);
      rx_a = 1'b0;
      tickn(20 * BIT);
      rx_a = 1'b1;
      tickn(2 * BIT);
      chk("break_pulses", 32'(brk_cnt_a), 32'(BRK_EN));
      chk("break_count_a", 32'(cnt_a), 0);
      chk("break_pending_a", 32'(q_a.size()), 0);

      // Reset mid-frame flushes the FIFO and the partial 0x81
      ready_a = 1'b0;
      send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1);
      chk("hold_count_a", 32'(cnt_a), 1);
      chk("hold_valid_a", 32'(valid_a), 1);
      rx_a = 1'b0;
      tickn(BIT);
      rx_a = 1'b1;              // bit 0 of 0x81
      tickn(BIT / 2);
      reset = 1'b1;
      tickn(1);
      reset = 1'b0;
      tickn(1);
      chk("midrst_valid_a", 32'(valid_a), 0);
      chk("midrst_count_a", 32'(cnt_a), 0);
      chk("midrst_data_a", 32'(data_a), 0);
      chk("midrst_fe_a", 32'(fe_a), 0);
      ready_a = 1'b1;
      tickn(2 * BIT);
      expect_a(9'h042, 1'b0, 1'b0);
      send_frame(0, 9'h042, 8, 0, 1'b0, 1'b1);
      tickn(BIT);
      chk("post_rst_pending_a", 32'(q_a.size()), 0);
      chk("post_rst_count_a", 32'(cnt_a), 0);

      // 7E1 parity: wrong then correct parity bit
      expect_b(9'h007, 1'b0, 1'b1);
      send_frame(1, 9'h007, 7, 1, 1'b0, 1'b1);
      expect_b(9'h007, 1'b0, 1'b0);
      send_frame(1, 9'h007, 7, 1, 1'b1, 1'b1);
      tickn(BIT);
      chk("par_pending_b", 32'(q_b.size()), 0);

      // Depth-4 overflow with consumer stalled
      ready_b = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         kb = 8'(k);
         if (k <= 4) expect_b({1'b0, kb}, 1'b0, 1'b0);
         send_frame(1, {1'b0, kb}, 7, 1, ^kb, 1'b1);
         if (k == 4) chk("ovf_before_5th", 32'(ovf_cnt_b), 0);
      end
      chk("full_count_b", 32'(cnt_b), 4);
      chk("full_valid_b", 32'(valid_b), 1);
      chk("ovf_pulses_b", 32'(ovf_cnt_b), 1);
      ready_b = 1'b1;
      tickn(20);
      chk("drain_count_b", 32'(cnt_b), 0);
      chk("drain_pending_b", 32'(q_b.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
